demux_1to4_buf: RTL and testbench
=================================

Name: demux_1to4_buf

Overview:
- Buffered 1-to-4 demultiplexer, the distribution counterpart of the datapath's 4-to-1 select muxes.
- Accepts one DATA_WIDTH word per cycle from a single source with a valid/ready handshake.
- Steers each word by select_i into one of four independent per-channel FIFOs, each drained by its own consumer.
- Used where one producer (e.g. the writeback/result path) must feed four sinks that stall independently.

Parameters:
- DATA_WIDTH, 32, width of every data word.
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.
- CW, log2(DEPTH)+1, width of each occupancy count (derived; not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- data_i  input  DATA_WIDTH  source word.
- select_i  input  2  destination channel for data_i; 00→ch0, 01→ch1, 10→ch2, 11→ch3.
- valid_i  input  1  source word valid.
- ready_o  output  1  selected channel can accept this cycle.
- data0_o..data3_o  output  DATA_WIDTH each  head-of-FIFO word per channel.
- valid0_o..valid3_o  output  1 each  channel k FIFO non-empty.
- ready0_i..ready3_i  input  1 each  consumer k takes the head word this cycle.
- count_o  output  4*CW  occupancy; channel k in bits [k*CW +: CW].

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All FIFO pointers and counts go to 0; storage is cleared to 0.
  - valid0_o..valid3_o=0, data0_o..data3_o=0, count_o=0.
  - ready_o=1 once out of reset (all channels empty).
- Reset asserted mid-operation discards all buffered words. No handshake completes on the clock edge at which rst_i is low.
- ready_o = NOT full[select_i], combinational from select_i and the registered counts. It does not depend on valid_i or ready*_i.
- Push: valid_i & ready_o at a rising edge writes data_i into channel select_i at its write pointer, then increments the write pointer (mod DEPTH) and count.
- Pop on channel k: validk_o & readyk_i at a rising edge increments read pointer k (mod DEPTH) and decrements count k.
- validk_o = (count_k != 0).
- datak_o = storage_k[rdptr_k], a combinational read of registered storage. It holds stable while validk_o=1 and readyk_i=0.
- Latency: a word pushed at edge N appears on datak_o/validk_o after edge N. There is no same-cycle bypass from data_i to datak_o.
- Simultaneous push and pop on the same channel:
  - Not full and not empty: both occur; count unchanged; pointers both advance.
  - Empty: only the push happens, since validk_o=0 and no pop can occur.
  - Full: ready_o=0, so only the pop happens. A full channel never accepts a word in the cycle it drains.
- Pushes to one channel and pops on other channels in the same cycle are fully independent.
- Full means count_k == DEPTH. While the source waits on a full channel it must hold data_i/select_i stable. Changing select_i to a non-full channel re-evaluates ready_o that same cycle.
- select_i and data_i are don't-care when valid_i=0. No state changes from them.
- readyk_i while validk_o=0 has no effect: no pointer movement, no count underflow.
- Pointer wrap: DEPTH-1 → 0. The count never exceeds DEPTH and never goes below 0.
- Ordering: strict FIFO order within each channel. No ordering guarantee across channels.

Test Plan:
- Reset, then push 0xA5A5A5A5 with select_i=10 and ready2_i=0. Required: ready_o=1; after the edge valid2_o=1, data2_o=0xA5A5A5A5, count_o ch2=1, other channels valid=0.
- Push 0x11 then 0x22 to ch1 (DEPTH=2) with ready1_i=0. Required: after the 2nd edge count=2 and ready_o=0 with select_i=01. Switching select_i to 00 gives ready_o=1 in the same cycle.
- Ch1 full {0x11,0x22}; assert ready1_i=1 and valid_i=1 with 0x33 on select_i=01. Required: only the pop occurs; data1_o=0x22, count=1, ready_o=1. The next edge pushes 0x33. Ch1 then drains in the order 0x22, 0x33.
- Wrap test: 6 interleaved push/pop pairs on ch3 with values 1..6, ready3_i=1 continuously. Required: data3_o emits 1..6 in order; count stays ≤1; pointers wrap correctly.
- All four channels hold one word each; pull rst_i low between clock edges. Required: all valid*_o=0, count_o=0 and data*_o=0 immediately, before the next clock edge.
- ready0_i=1 with ch0 empty, and valid_i=0 with select_i toggling randomly. Required: count_o stays 0 and no validk_o asserts.

Source files
------------

// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demultiplexer: one valid/ready source steered by select_i
// into four independent per-channel FIFOs, each drained by its own consumer.
module demux_1to4_buf #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 2,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [1:0]            select_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data0_o,
    output logic [DATA_WIDTH-1:0] data1_o,
    output logic [DATA_WIDTH-1:0] data2_o,
    output logic [DATA_WIDTH-1:0] data3_o,
    output logic                  valid0_o,
    output logic                  valid1_o,
    output logic                  valid2_o,
    output logic                  valid3_o,
    input  logic                  ready0_i,
    input  logic                  ready1_i,
    input  logic                  ready2_i,
    input  logic                  ready3_i,
    output logic [4*CW-1:0]       count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [3:0]            full;
    logic [3:0]            valid_v;
    logic [3:0]            pop_rdy;
    logic [DATA_WIDTH-1:0] head [4];

    assign pop_rdy = {ready3_i, ready2_i, ready1_i, ready0_i};

    // Only the addressed channel gates the source.
    assign ready_o = ~full[select_i];

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]         wr_ptr;
        logic [AW-1:0]         rd_ptr;
        logic [CW-1:0]         cnt;
        logic                  push;
        logic                  pop;

        assign push       = valid_i & ready_o & (select_i == 2'(k));
        assign pop        = valid_v[k] & pop_rdy[k];
        assign valid_v[k] = (cnt != '0);
        assign full[k]    = (cnt == CW'(DEPTH));
        assign head[k]    = mem[rd_ptr];

        assign count_o[k*CW +: CW] = cnt;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                if (push) begin
                    mem[wr_ptr] <= data_i;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                unique case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign data0_o  = head[0];
    assign data1_o  = head[1];
    assign data2_o  = head[2];
    assign data3_o  = head[3];
    assign valid0_o = valid_v[0];
    assign valid1_o = valid_v[1];
    assign valid2_o = valid_v[2];
    assign valid3_o = valid_v[3];

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Directed bench for demux_1to4_buf with a per-channel scoreboard model.
module tb_demux_1to4_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] din = '0;
    logic [1:0]    sel = '0;
    logic          valid = 1'b0;
    logic [3:0]    rdy = '0;
    logic          ready_o;
    logic [3:0]    vout;
    logic [4*CW-1:0] count_o;
    wire  [DW-1:0] dout [4];

    logic [DW-1:0] sb [4][$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_1to4_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .data_i(din), .select_i(sel), .valid_i(valid), .ready_o(ready_o),
        .data0_o(dout[0]), .data1_o(dout[1]),
        .data2_o(dout[2]), .data3_o(dout[3]),
        .valid0_o(vout[0]), .valid1_o(vout[1]),
        .valid2_o(vout[2]), .valid3_o(vout[3]),
        .ready0_i(rdy[0]), .ready1_i(rdy[1]),
        .ready2_i(rdy[2]), .ready3_i(rdy[3]),
        .count_o(count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("valid%0d", k), 64'(vout[k]),
                64'(sb[k].size() != 0));
            chk($sformatf("count%0d", k), 64'(count_o[k*CW +: CW]),
                64'(sb[k].size()));
            if (sb[k].size() != 0)
                chk($sformatf("data%0d", k), 64'(dout[k]), 64'(sb[k][0]));
        end
    endtask

    // One clock: predict the handshakes, take the edge, update model, compare.
    task automatic tick();
        logic       push;
        logic [3:0] pop;
        #1;
        push = valid && (sb[sel].size() < DEPTH);
        for (int k = 0; k < 4; k++)
            pop[k] = rdy[k] && (sb[k].size() != 0);
        chk("ready_o", 64'(ready_o), 64'(sb[sel].size() < DEPTH));
        @(posedge clk);
        for (int k = 0; k < 4; k++)
            if (pop[k]) void'(sb[k].pop_front());
        if (push) sb[sel].push_back(din);
        #1;
        compare_all();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_count", 64'(count_o), 64'h0);
        chk("rst_valid", 64'(vout), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(ready_o), 64'h1);
        compare_all();

        // Single push to ch2
        valid = 1'b1; sel = 2'b10; din = 32'hA5A5A5A5;
        tick();
        chk("t1_data2", 64'(dout[2]), 64'hA5A5A5A5);
        chk("t1_count2", 64'(count_o[2*CW +: CW]), 64'h1);
        chk("t1_others", 64'({vout[3], vout[1], vout[0]}), 64'h0);

        // Fill ch1, then ready_o follows select_i combinationally
        sel = 2'b01; din = 32'h11;
        tick();
        din = 32'h22;
        tick();
        chk("t2_count1", 64'(count_o[1*CW +: CW]), 64'h2);
        #1;
        chk("t2_ready_full", 64'(ready_o), 64'h0);
        sel = 2'b00;
        #1;
        chk("t2_ready_sel0", 64'(ready_o), 64'h1);

        // Full channel drains without accepting the waiting word
        sel = 2'b01; din = 32'h33; rdy[1] = 1'b1;
        tick();
        chk("t3_data1", 64'(dout[1]), 64'h22);
        chk("t3_count1", 64'(count_o[1*CW +: CW]), 64'h1);
        chk("t3_ready", 64'(ready_o), 64'h1);
        rdy[1] = 1'b0;
        tick();
        chk("t3_count1b", 64'(count_o[1*CW +: CW]), 64'h2);
        valid = 1'b0; rdy[1] = 1'b1;
        tick();
        chk("t3_drain33", 64'(dout[1]), 64'h33);
        tick();
        chk("t3_empty1", 64'(vout[1]), 64'h0);
        rdy[1] = 1'b0;

        // Interleaved push/pop on ch3 across several pointer wraps
        rdy[3] = 1'b1;
        for (int v = 1; v <= 6; v++) begin
            valid = 1'b1; sel = 2'b11; din = 32'(v);
            tick();
            chk("wrap_data3", 64'(dout[3]), 64'(v));
            valid = 1'b0;
            tick();
        end
        rdy[3] = 1'b0;

        // Idle source with random select, pop on empty ch0
        rdy[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            valid = 1'b0; sel = 2'($urandom_range(0, 3)); din = $urandom;
            tick();
            chk("idle_count0", 64'(count_o[0 +: CW]), 64'h0);
        end
        rdy[0] = 1'b0;

        // One word in every channel, then asynchronous reset mid-cycle
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k != 2) begin
                sel = 2'(k); din = 32'hC0DE_0000 + 32'(k);
                tick();
            end
        end
        valid = 1'b0;
        chk("pre_rst_valid", 64'(vout), 64'hF);
        #2;
        rst = 1'b0;
        #1;
        chk("async_count", 64'(count_o), 64'h0);
        chk("async_valid", 64'(vout), 64'h0);
        chk("async_data", 64'({dout[0], dout[1]}), 64'h0);
        chk("async_data23", 64'({dout[2], dout[3]}), 64'h0);
        for (int k = 0; k < 4; k++) sb[k].delete();
        @(negedge clk);
        rst = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
